// File: rtl/mult_control.sv
// mult_control: sequencing FSM for an 8-bit shift-add/subtract (Booth-style
// sign-corrected) multiplier. It drives the datapath strobes for the X:A
// accumulator and the B register and tracks the iteration index. The datapath
// itself lives elsewhere; this block only decides what happens each cycle.
module mult_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  input  logic       load_clr_i,
  input  logic       m_i,
  output logic       clr_xa_o,
  output logic       ld_b_o,
  output logic       ld_xa_o,
  output logic       sub_o,
  output logic       shift_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] cnt_o
);

  // State encoding kept as plain constants so the block drops into legacy
  // flows that do not understand enums.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [2:0] LAST_ITER = 3'd7;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [2:0] cnt;
  logic [2:0] cnt_next;
  logic       last_iter;

  assign last_iter = (cnt == LAST_ITER);

  // State and iteration counter registers; reset wins over every input.
  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // together from pre-edge values; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter update. In the run states the request inputs are
  // deliberately ignored; run_i only matters for starting and leaving HOLD.
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        // Load/clear has priority: asking for both never starts a run.
        if (load_clr_i) begin
          state_next = IDLE;
        end else if (run_i) begin
          state_next = CLR;
        end
      end
      CLR: begin
        cnt_next   = 3'd0;
        state_next = ADD;
      end
      ADD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        if (last_iter) begin
          cnt_next   = 3'd0;
          state_next = HOLD;
        end else begin
          cnt_next   = cnt + 3'd1;
          state_next = ADD;
        end
      end
      HOLD: begin
        // Staying here while run_i is held means one run per run_i pulse.
        if (!run_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Output decode. Strobes are mutually exclusive by construction apart from
  // the load/clear pair in IDLE, which the datapath expects together.
  always_comb begin
    clr_xa_o = 1'b0;
    ld_b_o   = 1'b0;
    ld_xa_o  = 1'b0;
    sub_o    = 1'b0;
    shift_o  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state)
      IDLE: begin
        clr_xa_o = load_clr_i;
        ld_b_o   = load_clr_i;
      end
      CLR: begin
        clr_xa_o = 1'b1;
        busy_o   = 1'b1;
      end
      ADD: begin
        // Only accumulate when the current multiplier bit is set; the last
        // (sign) bit is weighted negatively, hence the subtract.
        ld_xa_o = m_i;
        sub_o   = last_iter;
        busy_o  = 1'b1;
      end
      SHIFT: begin
        shift_o = 1'b1;
        busy_o  = 1'b1;
      end
      HOLD: begin
        done_o = 1'b1;
      end
      default: begin
        clr_xa_o = 1'b0;
      end
    endcase
  end

  assign cnt_o = cnt;

endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: directed bench for mult_control. Each cycle the expected
// output vector is derived from a sequence-position model and queued when the
// inputs are driven, then popped and compared at the following falling edge.
module tb_mult_control;

  logic       clk;
  logic       reset;
  logic       run_i;
  logic       load_clr_i;
  logic       m_i;
  logic       clr_xa_o;
  logic       ld_b_o;
  logic       ld_xa_o;
  logic       sub_o;
  logic       shift_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] cnt_o;

  mult_control dut (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run_i),
    .load_clr_i (load_clr_i),
    .m_i        (m_i),
    .clr_xa_o   (clr_xa_o),
    .ld_b_o     (ld_b_o),
    .ld_xa_o    (ld_xa_o),
    .sub_o      (sub_o),
    .shift_o    (shift_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cnt_o      (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {clr_xa, ld_b, ld_xa, sub, shift, busy, done, cnt[2:0]}
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int sh_cnt = 0;
  int sub_cnt = 0;
  int clr_cnt = 0;
  int ldb_cnt = 0;

  // Model position: -1 idle, 0 clear, 1..16 add/shift pairs, 17 hold.
  int pos = -1;

  logic [7:0] pattern = 8'b1101_0101; // bit i = m for iteration i

  function automatic logic [9:0] model_out(input logic lc, input logic m);
    logic [9:0] v;
    int it;
    v = '0;
    if (pos < 0) begin
      v[9] = lc;
      v[8] = lc;
    end else if (pos == 0) begin
      v[9] = 1'b1;
      v[4] = 1'b1;
    end else if (pos <= 16) begin
      it = (pos - 1) / 2;
      v[4] = 1'b1;
      v[2:0] = 3'(it);
      if (pos % 2 == 1) begin
        v[7] = m;
        v[6] = (it == 7);
      end else begin
        v[5] = 1'b1;
      end
    end else begin
      v[3] = 1'b1;
    end
    return v;
  endfunction

  function automatic int model_next(input logic rst, input logic run,
                                    input logic lc);
    if (rst) return -1;
    if (pos < 0) return (!lc && run) ? 0 : -1;
    if (pos < 17) return pos + 1;
    return run ? 17 : -1;
  endfunction

  function automatic logic pattern_m();
    int it;
    it = (pos >= 1 && pos <= 16) ? (pos - 1) / 2 : 0;
    return pattern[it];
  endfunction

  task automatic check(input string tag);
    logic [9:0] obs;
    logic [9:0] expv;
    obs = {clr_xa_o, ld_b_o, ld_xa_o, sub_o, shift_o, busy_o, done_o, cnt_o};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed=%b required=%b", tag, obs, expv);
      end
    end
    ld_cnt  += int'(ld_xa_o);
    sh_cnt  += int'(shift_o);
    sub_cnt += int'(sub_o);
    clr_cnt += int'(clr_xa_o);
    ldb_cnt += int'(ld_b_o);
  endtask

  task automatic check_count(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    ld_cnt = 0; sh_cnt = 0; sub_cnt = 0; clr_cnt = 0; ldb_cnt = 0;
  endtask

  task automatic step(input logic rst, input logic run, input logic lc,
                      input logic m, input string tag);
    @(posedge clk);
    #1;
    reset      = rst;
    run_i      = run;
    load_clr_i = lc;
    m_i        = m;
    exp_q.push_back(model_out(lc, m));
    @(negedge clk);
    check(tag);
    pos = model_next(rst, run, lc);
  endtask

  initial begin
    reset = 1'b1; run_i = 1'b0; load_clr_i = 1'b0; m_i = 1'b0;
    repeat (2) @(posedge clk);
    pos = -1;

    // Idle after reset: everything low.
    step(0, 0, 0, 0, "reset_idle");
    step(0, 0, 0, 1, "idle_quiet");

    // Load/clear pulse in IDLE.
    step(0, 0, 1, 0, "load_clr");
    step(0, 0, 0, 0, "after_load_clr");

    // m=1, single-cycle run pulse, then release.
    clear_counts();
    step(0, 1, 0, 1, "run1_start");
    for (int i = 1; i <= 20; i++) step(0, 0, 0, 1, "run1_seq");
    check_count("run1_ld_xa", ld_cnt, 8);
    check_count("run1_shift", sh_cnt, 8);
    check_count("run1_sub", sub_cnt, 1);
    check_count("run1_clr", clr_cnt, 1);

    // m=0, run held 40 cycles: one sequence only, no accumulates.
    clear_counts();
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, "run0_held");
    step(0, 0, 0, 0, "run0_release");
    step(0, 0, 0, 0, "run0_idle");
    check_count("run0_ld_xa", ld_cnt, 0);
    check_count("run0_shift", sh_cnt, 8);
    check_count("run0_clr", clr_cnt, 1);

    // Per-iteration multiplier pattern.
    clear_counts();
    step(0, 1, 0, pattern_m(), "pat_start");
    for (int i = 1; i <= 20; i++) step(0, 0, 0, pattern_m(), "pat_seq");
    check_count("pat_ld_xa", ld_cnt, 5);
    check_count("pat_sub", sub_cnt, 1);

    // Reset in the middle of a run, then a clean run.
    step(0, 1, 0, 1, "mid_start");
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, "mid_seq");
    step(1, 0, 0, 1, "mid_reset");
    step(0, 0, 0, 1, "mid_after_reset");
    clear_counts();
    step(0, 1, 0, 1, "rerun_start");
    for (int i = 1; i <= 20; i++) step(0, 0, 0, 1, "rerun_seq");
    check_count("rerun_shift", sh_cnt, 8);

    // run and load_clr together: load/clear only, no sequence.
    clear_counts();
    step(0, 1, 1, 0, "both_high");
    step(0, 0, 0, 0, "both_after");
    check_count("both_busy_free_shift", sh_cnt, 0);

    // load_clr pulsed during the run must not load B or disturb the run.
    clear_counts();
    step(0, 1, 0, 1, "lc_run_start");
    for (int i = 1; i <= 20; i++)
      step(0, 0, (i >= 3 && i <= 6), 1, "lc_run_seq");
    check_count("lc_run_ld_b", ldb_cnt, 0);
    check_count("lc_run_shift", sh_cnt, 8);
    check_count("lc_run_ld_xa", ld_cnt, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
